// File: rtl/store_unit_pkg.sv
// ----------------------------------------------------------------------------
// store_unit_pkg
// Shared types for the store unit: the store-size encoding carried on
// req_size and the state encoding of the store FSM.
// ----------------------------------------------------------------------------
package store_unit_pkg;

  // Encoding of req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  // Store FSM states. IDLE is the only state that accepts a request.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    ERR   = 2'b11
  } state_t;

  // Number of byte lanes in one memory word.
  localparam int LANES = 4;

endpackage

// File: rtl/store_lane_align.sv
// ----------------------------------------------------------------------------
// store_lane_align
// Combinational lane math for a store that may straddle two memory words.
// The payload (1, 2 or 4 low bytes of data) is shifted up by the byte offset
// into a 64-bit window covering the addressed word and the next one.
//
// Ports
//   offset : byte offset inside the word (addr[1:0])
//   size   : store size (SZ_BYTE/SZ_HALF/SZ_WORD; SZ_ILL yields no lanes)
//   data   : register data, payload in the low bytes
//   mask8  : byte enables for the 8-byte window; [3:0] word 0, [7:4] word 1
//   wide64 : lane-aligned data for the window; unused lanes are 0
// ----------------------------------------------------------------------------
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic [31:0] data,
  output logic [7:0]  mask8,
  output logic [63:0] wide64
);

  logic [3:0]  w_mask4;
  logic [63:0] w_data_ext;

  // Pick the payload bytes and their unshifted mask; the high bytes of the
  // register are dropped here so they can never reach an unused lane.
  always_comb begin
    w_mask4    = 4'b0000;
    w_data_ext = 64'd0;
    case (size)
      SZ_BYTE: begin
        w_mask4    = 4'b0001;
        w_data_ext = {56'd0, data[7:0]};
      end
      SZ_HALF: begin
        w_mask4    = 4'b0011;
        w_data_ext = {48'd0, data[15:0]};
      end
      SZ_WORD: begin
        w_mask4    = 4'b1111;
        w_data_ext = {32'd0, data};
      end
      default: begin
        w_mask4    = 4'b0000;
        w_data_ext = 64'd0;
      end
    endcase
  end

  assign mask8  = {4'b0000, w_mask4} << offset;
  assign wide64 = w_data_ext << {offset, 3'b000};

endmodule

// File: rtl/store_unit.sv
// ----------------------------------------------------------------------------
// store_unit
// Turns a byte/half/word store request into one or two word-aligned memory
// write beats with byte enables. Misaligned stores that cross a word
// boundary are either split into two beats (MISALIGN_SPLIT=1) or rejected
// (MISALIGN_SPLIT=0). Illegal sizes are always rejected.
//
// Handshakes: both the request and memory sides use valid/ready. A transfer
// happens on a rising edge where valid and ready are both high. The request
// side is ready only in IDLE. Once mem_valid rises, mem_addr, mem_wdata and
// mem_be stay constant until the cycle in which mem_ready is seen high.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_addr/data/size    : store address, register data, size encoding
//   mem_valid/mem_ready   : memory write beat handshake
//   mem_addr/wdata/be     : word-aligned address, lane data, byte enables
//   done                  : pulse in the cycle the final beat is accepted
//   err                   : pulse for the single cycle a store is rejected
//   dbg_state             : current FSM state, for observation only
// ----------------------------------------------------------------------------
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [LANES-1:0]      mem_be,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                r_state;
  logic                  r_mem_valid;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [LANES-1:0]      r_mem_be;
  // Second-beat contents captured at acceptance, so the request bus is free
  // to change while the store is in flight.
  logic                  r_split;
  logic [LANES-1:0]      r_hi_be;
  logic [DATA_WIDTH-1:0] r_hi_wdata;

  logic [7:0]            w_mask8;
  logic [63:0]           w_wide64;
  logic                  w_split;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_reject;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  store_lane_align u_lane_align (
    .offset (req_addr[1:0]),
    .size   (size_t'(req_size)),
    .data   (req_data),
    .mask8  (w_mask8),
    .wide64 (w_wide64)
  );

  assign w_split     = |w_mask8[7:4];
  assign w_illegal   = (size_t'(req_size) == SZ_ILL);
  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_reject    = w_illegal || (w_split && (MISALIGN_SPLIT == 0));
  assign w_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_split     <= 1'b0;
      r_hi_be     <= '0;
      r_hi_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_split    <= w_split;
            r_hi_be    <= w_mask8[7:4];
            r_hi_wdata <= w_wide64[63:32];
            if (w_reject) begin
              r_state <= ERR;
            end else begin
              r_state     <= BEAT0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_be    <= w_mask8[3:0];
              r_mem_wdata <= w_wide64[31:0];
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (r_split) begin
              r_state     <= BEAT1;
              r_mem_addr  <= r_mem_addr + WORD_STEP;
              r_mem_be    <= r_hi_be;
              r_mem_wdata <= r_hi_wdata;
            end else begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_be    <= '0;
              r_mem_wdata <= '0;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
          end
        end
        ERR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  // done marks the cycle whose rising edge retires the final beat, so it
  // never overlaps IDLE and a new request waits for the following cycle.
  assign done      = mem_ready && (((r_state == BEAT0) && !r_split) ||
                                   (r_state == BEAT1));
  assign err       = (r_state == ERR);
  assign dbg_state = r_state;

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the register/memory word width; only 32 is supported.
REQ-003 The block SHALL have parameter MISALIGN_SPLIT, default 1; 1 = split misaligned stores into two beats, 0 = flag them as an error.
REQ-004 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port req_valid, input, 1: store request present.
REQ-007 Port req_ready, output, 1: the block can accept a request.
REQ-008 Port req_addr, input, ADDR_WIDTH: byte address.
REQ-009 Port req_data, input, DATA_WIDTH: register data, with the payload in the low bytes.
REQ-010 Port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 Port mem_valid, output, 1: memory write beat valid.
REQ-012 Port mem_ready, input, 1: memory accepts the beat.
REQ-013 Port mem_addr, output, ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
REQ-014 Port mem_wdata, output, DATA_WIDTH: lane-aligned write data.
REQ-015 Port mem_be, output, 4: byte enables, with bit i covering mem_wdata[8i+7:8i].
REQ-016 Port done, output, 1: one-cycle pulse when a store completes.
REQ-017 Port err, output, 1: one-cycle pulse when a store is rejected.

Function
REQ-018 The FSM SHALL have states IDLE, BEAT0, BEAT1 and ERR, and req_ready SHALL equal (state==IDLE).
- A request is accepted on req_valid && req_ready.
- On acceptance, addr, data and size are latched.
REQ-019 Lane math:
- off = addr[1:0]; n = 1, 2 or 4 bytes.
- mask8 = ((1<<n)-1) << off.
- wide64 = zero-extended data[8n-1:0] << 8*off.
- Beat0 uses be = mask8[3:0] and wdata = wide64[31:0].
- Beat1 uses be = mask8[7:4] and wdata = wide64[63:32].
- Unused lanes SHALL be driven 0.
REQ-020 A store is "split" when mask8[7:4] != 0 (half at off=3, word at off!=0).
REQ-021 On acceptance, the next state SHALL be:
- ERR if size==11, or if the store is split and MISALIGN_SPLIT==0;
- otherwise BEAT0.
REQ-022 In BEAT0, mem_valid=1 and mem_addr={addr[ADDR_WIDTH-1:2],2'b00}; mem_addr, mem_wdata and mem_be SHALL hold stable until mem_ready.
REQ-023 On BEAT0 with mem_ready: go to BEAT1 if split, else go to IDLE and pulse done in the same cycle.
REQ-024 In BEAT1, mem_valid=1 and mem_addr = BEAT0 address + 4, wrapping modulo 2^ADDR_WIDTH; on mem_ready, go to IDLE and pulse done.
REQ-025 ERR SHALL last exactly one cycle with err=1 and mem_valid=0, then go to IDLE; no memory beat is issued for a rejected store.
REQ-026 Latency: with mem_ready held high, an aligned store reaches done one cycle after acceptance, and a split store two cycles after acceptance.
REQ-027 A new request SHALL NOT be accepted in the cycle done or err is pulsed; it is accepted in the following IDLE cycle.
REQ-028 done and err SHALL never be asserted together.

Reset
REQ-029 On rst_n low, the block SHALL immediately enter IDLE with mem_valid=0, done=0, err=0, mem_be=0, mem_wdata=0, mem_addr=0 and all latched fields zeroed; req_ready becomes 1.
REQ-030 Reset during BEAT0 or BEAT1 SHALL abandon the store: no done pulse and no further beats; a beat already accepted by memory is not undone.

Structure
REQ-031 A shared package SHALL hold the store-size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and the FSM state enum.
REQ-032 Lane math (REQ-019) SHALL be a combinational sub-module store_lane_align (inputs: offset, size, data; outputs: mask8, wide64), instantiated once.

Verification
REQ-033 Byte store: addr=0x103, data=0xAABBCCDD, size=00, mem_ready=1 -> one beat with mem_addr=0x100, be=1000, wdata=0xDD000000; done one cycle after acceptance.
REQ-034 Split word: addr=0x202, data=0x11223344, size=10 -> beat0 mem_addr=0x200, be=1100, wdata=0x33440000; beat1 mem_addr=0x204, be=0011, wdata=0x00001122; done after beat1.
REQ-035 Backpressure: aligned word at 0x40, mem_ready low for 3 cycles -> mem_valid, addr, data and be stay stable for 4 cycles, req_ready=0 throughout, single done.
REQ-036 Illegal size (11), and split half at off=3 with MISALIGN_SPLIT=0 -> err pulse one cycle after acceptance, mem_valid never asserted, req_ready returns to 1.
REQ-037 rst_n asserted in BEAT1 of a split store -> mem_valid drops immediately, no done, req_ready=1 after release.
REQ-038 Wrap-around: word at addr=0xFFFFFFFE -> beat0 at 0xFFFFFFFC, beat1 at 0x00000000.
